// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between the CPU and DMA ports.
// Grant is combinational in the request cycle and read data returns with a registered valid one cycle later; losers stall until granted.
module mem_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    c_cmd,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic          c_lock,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic [1:0]    d_cmd,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_C = 2'b01,
    OWN_D = 2'b10
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lw;        // 0: CPU won last, 1: DMA won last
  logic          r_c_rvalid;
  logic          r_d_rvalid;

  logic w_c_req;
  logic w_d_req;
  logic w_c_win;
  logic w_d_win;
  logic w_c_hold;
  logic w_d_hold;

  // Requests are masked during reset so no grant or write can escape.
  assign w_c_req = reset & ((c_cmd == 2'b01) | (c_cmd == 2'b10));
  assign w_d_req = reset & ((d_cmd == 2'b01) | (d_cmd == 2'b10));

  assign w_c_hold = (r_state == OWN_C) & c_lock & (r_cnt < MAXB);
  assign w_d_hold = (r_state == OWN_D) & d_lock & (r_cnt < MAXB);

  always_comb begin
    w_c_win = 1'b0;
    w_d_win = 1'b0;
    if (w_c_req && w_d_req) begin
      if (r_state == IDLE) begin
        w_c_win = 1'b1;
      end else if (w_c_hold) begin
        w_c_win = 1'b1;
      end else if (w_d_hold) begin
        w_d_win = 1'b1;
      end else if (r_lw) begin
        w_c_win = 1'b1;
      end else begin
        w_d_win = 1'b1;
      end
    end else begin
      w_c_win = w_c_req;
      w_d_win = w_d_req;
    end
  end

  assign c_gnt = w_c_win;
  assign d_gnt = w_d_win;

  always_comb begin
    ram_addr  = c_addr;
    ram_din   = '0;
    ram_write = 1'b0;
    if (w_c_win) begin
      ram_addr  = c_addr;
      ram_din   = c_wdata;
      ram_write = (c_cmd == 2'b10);
    end else if (w_d_win) begin
      ram_addr  = d_addr;
      ram_din   = d_wdata;
      ram_write = (d_cmd == 2'b10);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lw       <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_win & (c_cmd == 2'b01);
      r_d_rvalid <= w_d_win & (d_cmd == 2'b01);
      if (w_c_win) begin
        r_state <= OWN_C;
        r_lw    <= 1'b0;
        if (r_state != OWN_C) begin
          r_cnt <= CW'(1);
        end else if (r_cnt < MAXB) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (w_d_win) begin
        r_state <= OWN_D;
        r_lw    <= 1'b1;
        if (r_state != OWN_D) begin
          r_cnt <= CW'(1);
        end else if (r_cnt < MAXB) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end
    end
  end

  assign c_rvalid = r_c_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign c_rdata  = r_c_rvalid ? ram_dout : '0;
  assign d_rdata  = r_d_rvalid ? ram_dout : '0;
  assign owner    = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single 16-bit instruction/data RAM between the CPU memory interface and a second requester (DMA/program loader). It sits between the CPU's mem_cmd/mem_addr/out signals and the RAM. It grants one requester per cycle and steers address and write data to the RAM. It returns read data with a registered valid strobe. Fairness is round-robin, with an optional bounded lock for bursts.

Parameters:
AW, 9, address width (matches mem_addr)
DW, 16, data width
MAX_BURST, 4, max consecutive locked grants to one owner while the other is waiting (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
c_cmd  in  2  CPU command: 00 none, 01 read, 10 write, 11 treated as none
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_lock  in  1  CPU requests to hold ownership across cycles
c_gnt  out  1  CPU request accepted this cycle
c_rvalid  out  1  CPU read data valid (cycle after granted read)
c_rdata  out  DW  CPU read data
d_cmd, d_addr, d_wdata, d_lock, d_gnt, d_rvalid, d_rdata  same as c_* for the DMA port
ram_addr  out  AW  RAM address
ram_write  out  1  RAM write enable
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data, valid one cycle after address (synchronous read)
owner  out  2  00 idle, 01 CPU, 10 DMA (registered state, for debug)

Behaviour:
- State register: IDLE, OWN_C, OWN_D. Burst counter cnt (width clog2(MAX_BURST)+1). Last-winner bit lw.
- A port is requesting when its cmd is 01 or 10.
- Winner is chosen combinationally each cycle from the current state and requests:
  - Neither requesting: no winner.
  - One requesting: that port wins.
  - Both requesting, state IDLE: CPU wins.
  - Both requesting, owner has lock=1 and cnt<MAX_BURST: owner keeps the grant.
  - Both requesting otherwise: the port that is not lw wins (strict alternation).
- x_gnt = 1 iff x is the winner. The requester must hold cmd/addr/wdata stable until gnt is seen. A granted command completes in that cycle.
- RAM muxing: ram_addr/ram_din come from the winner. ram_write=1 iff the winner cmd=10. With no winner: ram_write=0, ram_addr=c_addr, ram_din=0.
- Read return:
  - x_rvalid is registered: 1 in the cycle after x was granted a read, else 0.
  - x_rdata = ram_dout when x_rvalid=1, else 0.
  - Back-to-back reads, including alternating ports, give one rvalid per cycle with no bubbles.
- Next state: winner C -> OWN_C, winner D -> OWN_D, no winner -> IDLE. lw <= winner whenever there is a winner.
- cnt:
  - Set to 1 when the winner differs from the current owner.
  - Incremented (saturating at MAX_BURST) when the same owner wins again.
  - Set to 0 in IDLE.
- Lock handling:
  - Lock is only honoured for the current owner while it keeps requesting.
  - Dropping cmd to 00 releases ownership immediately, even if lock=1.
  - Lock with no competitor grants indefinitely; cnt saturates and gives no penalty.
- Forced yield: when an owner reaches cnt==MAX_BURST with the other port waiting, the other port wins next. That port gets at least one grant before the first owner can win again.
- Reset (reset==0 at a clock edge): state IDLE, cnt 0, lw 0, both rvalid 0, owner 00.
- While reset is low, both gnt=0 and ram_write=0, regardless of inputs.
- Reset asserted mid-burst or with a read in flight: the pending rvalid is dropped (0 next cycle) and no grant is issued.
- Simultaneous write and read to the same address from different ports resolve purely by grant order. Read-during-write ordering is the RAM's property; the arbiter adds none.

Test Plan:
- Reset then single CPU read: c_cmd=01, c_addr=9'h005, RAM[5]=16'hBEEF -> c_gnt=1 in cycle 0; c_rvalid=1 with c_rdata=16'hBEEF in cycle 1; d_gnt=0 throughout; owner=01.
- Both ports request continuous reads from IDLE with no lock -> grants C,D,C,D...; rvalid strobes alternate one cycle later; ram_addr alternates c_addr/d_addr.
- DMA lock burst, MAX_BURST=4: d_lock=1, d_cmd=10 at addrs 0x10..0x15, CPU reading continuously -> d_gnt for 4 cycles, then c_gnt 1 cycle, then d_gnt resumes; RAM[0x10..0x13] written first.
- Lock with no competitor: d_lock=1, 8 writes, c_cmd=00 -> d_gnt=1 for all 8 cycles; cnt saturates at 4; no stall.
- Owner releases: C owns with lock=1, sets c_cmd=00 while D requests -> d_gnt=1 in that same cycle; owner=10 next cycle.
- Reset mid-read: CPU read granted, reset=0 on the next edge -> c_rvalid=0, owner=00, both gnt=0 and ram_write=0 while reset is low; first request after release from IDLE with both requesting goes to CPU.
